// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter
// that owns the shared OR-combined resource.
interface gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  REQ;
  logic [N-1:0]  GNT;
  logic [IW-1:0] GNT_ID;
  logic          BUSY;
  logic          ANY_REQ;
  logic          TMO;

  // requester side
  modport master (
    output REQ,
    input  GNT, GNT_ID, BUSY, ANY_REQ, TMO
  );

  // arbiter side
  modport slave (
    input  REQ,
    output GNT, GNT_ID, BUSY, ANY_REQ, TMO
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb.sv
// Round-robin arbiter: one-hot registered grant, rotating priority, GAP turnaround.
// Watchdog revoke compiled in with GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN.
module gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb #(
  parameter int N       = 4,
  parameter int TMO_CYC = 15
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8) begin : g_bad_n
    $error("N must be in 2..8");
  end
  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
    $error("TMO_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_gnt_id, w_id_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   w_ptr_adv;
  logic [IW-1:0]   w_pick;
  logic            w_pick_vld;
  logic [N-1:0][IW-1:0] w_cand;

`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TMO_CYC - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_tmo, w_tmo_nxt;
`endif

  // w_cand[k] is the requester examined k-th when scanning from r_ptr
  for (genvar k = 0; k < N; k++) begin : g_cand
    assign w_cand[k] = IW'((int'(r_ptr) + k) % N);
  end

  // highest offset first so the lowest offset with a request wins
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.REQ[w_cand[k]]) begin
        w_pick     = w_cand[k];
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_ptr_adv = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_gnt_id;
    w_ptr_nxt   = r_ptr;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt         = '0;
          w_gnt_nxt[w_pick] = 1'b1;
          w_id_nxt          = w_pick;
          w_state_nxt       = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.REQ[r_gnt_id]) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = S_GAP;
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_gnt_nxt   = '0;
          w_tmo_nxt   = 1'b1;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = S_GAP;
        end
        else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      S_GAP: begin
        w_gnt_nxt   = '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gnt_id <= w_id_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tmo <= w_tmo_nxt;
    end
  end
  assign bus.TMO = r_tmo;
`else
  assign bus.TMO = 1'b0;
`endif

  assign bus.GNT     = r_gnt;
  assign bus.GNT_ID  = r_gnt_id;
  assign bus.BUSY    = |r_gnt;
  assign bus.ANY_REQ = |bus.REQ;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb.sv
// Self-checking bench for the round-robin arbiter: directed scenarios plus
// random request traffic checked against a holder/pointer reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb;
  localparam int N       = 4;
  localparam int TMO_CYC = 5;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb_if #(.N(N)) bus ();

  gf180mcu_fd_sc_mcu7t5v0__or2_rr_arb #(.N(N), .TMO_CYC(TMO_CYC)) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: who holds the resource, whether the turnaround is pending
  int m_ptr, m_holder, m_cnt, m_id;
  bit m_gap, m_tmo;

  task automatic model_reset();
    m_ptr = 0; m_holder = -1; m_cnt = 0; m_id = 0; m_gap = 0; m_tmo = 0;
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_holder >= 0) ? (N'(1) << m_holder) : '0;
  endfunction

  function automatic bit req_bit(input logic [N-1:0] r, input int i);
    return ((r >> i) & N'(1)) != '0;
  endfunction

  task automatic model_step(input logic [N-1:0] r);
    bit found;
    found = 0;
    m_tmo = 0;
    if (m_gap) begin
      m_gap = 0;
      m_cnt = 0;
    end else if (m_holder < 0) begin
      for (int k = 0; k < N; k++)
        if (!found && req_bit(r, (m_ptr + k) % N)) begin
          found = 1;
          m_holder = (m_ptr + k) % N;
          m_id = m_holder;
        end
    end else if (!req_bit(r, m_holder)) begin
      m_ptr = (m_holder + 1) % N; m_holder = -1; m_gap = 1;
    end else if (TMO_EN && m_cnt == TMO_CYC - 1) begin
      m_tmo = 1; m_ptr = (m_holder + 1) % N; m_holder = -1; m_gap = 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic tick(input logic [N-1:0] r);
    bus.REQ = r;
    @(posedge CLK);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.REQ = '0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.REQ = '0;
    #12;
    n_checks++; if (bus.GNT !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", bus.GNT); else n_pass++;
    n_checks++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.BUSY); else n_pass++;
    n_checks++; if (bus.TMO !== 1'b0) $display("FAIL reset_tmo got %b exp 0", bus.TMO); else n_pass++;
    n_checks++; if (bus.GNT_ID !== 2'd0) $display("FAIL reset_gnt_id got %0d exp 0", bus.GNT_ID); else n_pass++;
    bus.REQ = 4'b1000; #1;
    n_checks++; if (bus.ANY_REQ !== 1'b1) $display("FAIL any_req_in_reset got %b exp 1", bus.ANY_REQ); else n_pass++;
    bus.REQ = 4'b0000; #1;
    n_checks++; if (bus.ANY_REQ !== 1'b0) $display("FAIL any_req_zero got %b exp 0", bus.ANY_REQ); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    tick(4'b0100);
    n_checks++; if (bus.GNT !== 4'b0100) $display("FAIL single_gnt got %b exp 0100", bus.GNT); else n_pass++;
    n_checks++; if (bus.GNT_ID !== 2'd2) $display("FAIL single_id got %0d exp 2", bus.GNT_ID); else n_pass++;
    n_checks++; if (bus.BUSY !== 1'b1) $display("FAIL single_busy got %b exp 1", bus.BUSY); else n_pass++;
    tick(4'b0100);
    n_checks++; if (bus.GNT !== 4'b0100) $display("FAIL single_hold got %b exp 0100", bus.GNT); else n_pass++;
    tick(4'b0000);
    n_checks++; if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) $display("FAIL single_release gnt %b busy %b exp 0000/0", bus.GNT, bus.BUSY); else n_pass++;
    tick(4'b0000);
    n_checks++; if (bus.GNT !== 4'b0000) $display("FAIL single_gap got %b exp 0000", bus.GNT); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] oh;
    int w;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      w = 0;
      do begin tick(4'b1111); w++; end while (bus.GNT === 4'b0000 && w < 6);
      oh = N'(1) << order[g];
      n_checks++; if (bus.GNT !== oh) $display("FAIL rr_grant%0d got %b exp %b", g, bus.GNT, oh); else n_pass++;
      n_checks++; if (w != ((g == 0) ? 1 : 2)) $display("FAIL rr_latency%0d got %0d cycles exp %0d", g, w, (g == 0) ? 1 : 2); else n_pass++;
      tick(4'b1111);
      tick(4'b1111);
      n_checks++; if (bus.GNT !== oh) $display("FAIL rr_hold%0d got %b exp %b", g, bus.GNT, oh); else n_pass++;
      tick(4'b1111 & ~oh);
      n_checks++; if (bus.GNT !== 4'b0000) $display("FAIL rr_release%0d got %b exp 0000", g, bus.GNT); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(4'b0100);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b1000);
    n_checks++; if (bus.GNT !== 4'b1000) $display("FAIL wrap_grant3 got %b exp 1000", bus.GNT); else n_pass++;
    tick(4'b0001);
    n_checks++; if (bus.GNT !== 4'b0000) $display("FAIL wrap_release got %b exp 0000", bus.GNT); else n_pass++;
    tick(4'b1001);
    tick(4'b1001);
    n_checks++; if (bus.GNT !== 4'b0001 || bus.GNT_ID !== 2'd0) $display("FAIL wrap_grant0 got %b id %0d exp 0001 id 0", bus.GNT, bus.GNT_ID); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    tick(4'b0011);
    n_checks++; if (bus.GNT !== 4'b0001) $display("FAIL tmo_first got %b exp 0001", bus.GNT); else n_pass++;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OR2_RR_ARB_TIMEOUT_EN
    for (int i = 1; i < TMO_CYC; i++) begin
      tick(4'b0011);
      n_checks++; if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0) $display("FAIL tmo_hold%0d gnt %b tmo %b exp 0001/0", i, bus.GNT, bus.TMO); else n_pass++;
    end
    tick(4'b0011);
    n_checks++; if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b1) $display("FAIL tmo_revoke gnt %b tmo %b exp 0000/1", bus.GNT, bus.TMO); else n_pass++;
    tick(4'b0011);
    n_checks++; if (bus.GNT !== 4'b0000 || bus.TMO !== 1'b0) $display("FAIL tmo_after gnt %b tmo %b exp 0000/0", bus.GNT, bus.TMO); else n_pass++;
    tick(4'b0011);
    n_checks++; if (bus.GNT !== 4'b0010 || bus.GNT_ID !== 2'd1) $display("FAIL tmo_next gnt %b id %0d exp 0010 id 1", bus.GNT, bus.GNT_ID); else n_pass++;
`else
    for (int i = 0; i < 100; i++) begin
      tick(4'b0011);
      n_checks++; if (bus.GNT !== 4'b0001 || bus.TMO !== 1'b0) $display("FAIL notmo_hold%0d gnt %b tmo %b exp 0001/0", i, bus.GNT, bus.TMO); else n_pass++;
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(4'b0010);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0010);
    n_checks++; if (bus.GNT !== 4'b0010) $display("FAIL rstmid_pre got %b exp 0010", bus.GNT); else n_pass++;
    #3;
    RST = 1'b1;
    #1;
    n_checks++; if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) $display("FAIL rstmid_async gnt %b busy %b exp 0000/0", bus.GNT, bus.BUSY); else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    tick(4'b0011);
    n_checks++; if (bus.GNT !== 4'b0001) $display("FAIL rstmid_after got %b exp 0001", bus.GNT); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] eg;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(3) == 0) r = r ^ (N'(1) << b);
      tick(r);
      eg = m_gnt();
      n_checks++; if (bus.GNT !== eg) $display("FAIL rand_gnt c%0d got %b exp %b", c, bus.GNT, eg); else n_pass++;
      n_checks++; if (bus.BUSY !== (|eg)) $display("FAIL rand_busy c%0d got %b exp %b", c, bus.BUSY, |eg); else n_pass++;
      n_checks++; if (bus.TMO !== m_tmo) $display("FAIL rand_tmo c%0d got %b exp %b", c, bus.TMO, m_tmo); else n_pass++;
      n_checks++; if (bus.ANY_REQ !== (|r)) $display("FAIL rand_any c%0d got %b exp %b", c, bus.ANY_REQ, |r); else n_pass++;
      if (m_holder >= 0) begin
        n_checks++; if (bus.GNT_ID !== 2'(m_id)) $display("FAIL rand_id c%0d got %0d exp %0d", c, bus.GNT_ID, m_id); else n_pass++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  initial begin
    bus.REQ = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
